// File: rtl/reg_wb_sequencer_if.sv
// Handshake and register-bank control bundle between the main control FSM
// and the write-back sequencer.
interface reg_wb_sequencer_if;
  logic       start;
  logic [2:0] op;
  logic       needs_mem;
  logic       mem_ready;
  logic [2:0] reg_dst_sel;
  logic [1:0] wb_src_sel;
  logic       reg_write;
  logic       busy;
  logic       done;
  logic       err;

  modport master (
    output start, op, needs_mem, mem_ready,
    input  reg_dst_sel, wb_src_sel, reg_write, busy, done, err
  );

  modport slave (
    input  start, op, needs_mem, mem_ready,
    output reg_dst_sel, wb_src_sel, reg_write, busy, done, err
  );
endinterface

// File: rtl/reg_wb_sequencer.sv
// Register-bank write-back sequencer: turns a one-cycle command into one or two
// ordered register writes, waiting on memory data and flagging illegal ops or timeouts.
module reg_wb_sequencer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input logic                clk,
  input logic                reset,
  reg_wb_sequencer_if.slave  bus
);

  localparam logic [2:0] OpRtype  = 3'b000;
  localparam logic [2:0] OpItype  = 3'b001;
  localparam logic [2:0] OpJal    = 3'b010;
  localparam logic [2:0] OpPush   = 3'b011;
  localparam logic [2:0] OpPop    = 3'b100;
  localparam logic [2:0] OpRswr   = 3'b101;

  typedef enum logic [2:0] {StIdle, StWaitMem, StWr1, StWr2, StFin} state_e;

  state_e           state_q, state_d;
  logic [2:0]       op_q, op_d;
  logic             ld_q, ld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       dst_q, dst_d;
  logic [1:0]       src_q, src_d;
  logic             we_q, we_d;
  logic             busy_q, done_q, err_q, err_d;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ld_d    = ld_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          op_d  = bus.op;
          ld_d  = bus.needs_mem;
          cnt_d = '0;
          if (bus.op[2:1] == 2'b11) begin
            state_d = StFin;
            err_d   = 1'b1;
          end else if (bus.op == OpPop || (bus.op == OpItype && bus.needs_mem)) begin
            state_d = StWaitMem;
          end else begin
            state_d = StWr1;
          end
        end
      end
      StWaitMem: begin
        // mem_ready wins even in the cycle the counter would hit the limit
        if (bus.mem_ready) begin
          state_d = StWr1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d >= CNT_W'(MEM_TIMEOUT)) begin
            state_d = StFin;
            err_d   = 1'b1;
            cnt_d   = '0;
          end
        end
      end
      StWr1:   state_d = (op_q == OpPop) ? StWr2 : StFin;
      StWr2:   state_d = StFin;
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the state being entered.
  always_comb begin
    we_d  = 1'b0;
    dst_d = dst_q;
    src_d = src_q;
    if (state_d == StWr1) begin
      we_d = 1'b1;
      case (op_d)
        OpRtype: begin dst_d = 3'b001; src_d = 2'b00; end
        OpItype: begin dst_d = 3'b000; src_d = ld_d ? 2'b01 : 2'b00; end
        OpJal:   begin dst_d = 3'b011; src_d = 2'b10; end
        OpPush:  begin dst_d = 3'b010; src_d = 2'b11; end
        OpPop:   begin dst_d = 3'b000; src_d = 2'b01; end
        OpRswr:  begin dst_d = 3'b100; src_d = 2'b00; end
        default: begin dst_d = dst_q;  src_d = src_q;  end
      endcase
    end else if (state_d == StWr2) begin
      we_d  = 1'b1;
      dst_d = 3'b010;
      src_d = 2'b11;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      ld_q    <= 1'b0;
      cnt_q   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      dst_q   <= dst_d;
      src_q   <= src_d;
      we_q    <= we_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFin);
      err_q   <= err_d;
    end
  end

  assign bus.reg_dst_sel = dst_q;
  assign bus.wb_src_sel  = src_q;
  assign bus.reg_write   = we_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Bench for reg_wb_sequencer: per-cycle comparison against a command-level
// expected-trace model, plus literal checks on write counts and ordering.
module tb_reg_wb_sequencer;

  localparam int unsigned MEM_TIMEOUT = 15;

  logic clk = 1'b0;
  logic reset = 1'b1;
  reg_wb_sequencer_if bus ();

  reg_wb_sequencer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       we;
    logic [2:0] dst;
    logic [1:0] src;
    logic       done;
    logic       err;
  } exp_t;

  exp_t       q[$];
  logic [2:0] hd = '0;
  logic [1:0] hs = '0;
  int checks = 0;
  int errors = 0;
  int wr_n, done_n, err_n, busy_n;
  logic [4:0] wlog[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t mk(logic b, logic w, logic [2:0] d, logic [1:0] s, logic dn,
                              logic e);
    exp_t r;
    r.busy = b; r.we = w; r.dst = d; r.src = s; r.done = dn; r.err = e;
    return r;
  endfunction

  // Expected per-cycle trace of one command, starting with its start cycle.
  task automatic plan(input logic [2:0] o, input logic nm, input int wait_lo, output int len);
    int n0 = q.size();
    logic [2:0] d = '0;
    logic [1:0] s = '0;
    q.push_back(mk(0, 0, 0, 0, 0, 0));
    if (o == 3'd6 || o == 3'd7) begin
      q.push_back(mk(1, 0, 0, 0, 1, 1));
    end else begin
      if (o == 3'd4 || (o == 3'd1 && nm)) begin
        if (wait_lo >= int'(MEM_TIMEOUT)) begin
          for (int i = 0; i < int'(MEM_TIMEOUT); i++) q.push_back(mk(1, 0, 0, 0, 0, 0));
          q.push_back(mk(1, 0, 0, 0, 1, 1));
          len = q.size() - n0 - 1;
          return;
        end
        for (int i = 0; i <= wait_lo; i++) q.push_back(mk(1, 0, 0, 0, 0, 0));
      end
      case (o)
        3'd0: begin d = 3'b001; s = 2'b00; end
        3'd1: begin d = 3'b000; s = nm ? 2'b01 : 2'b00; end
        3'd2: begin d = 3'b011; s = 2'b10; end
        3'd3: begin d = 3'b010; s = 2'b11; end
        3'd4: begin d = 3'b000; s = 2'b01; end
        default: begin d = 3'b100; s = 2'b00; end
      endcase
      q.push_back(mk(1, 1, d, s, 0, 0));
      if (o == 3'd4) q.push_back(mk(1, 1, 3'b010, 2'b11, 0, 0));
      q.push_back(mk(1, 0, 0, 0, 1, 0));
    end
    len = q.size() - n0 - 1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    e = '0;
    if (q.size() > 0) e = q.pop_front();
    if (e.we) begin hd = e.dst; hs = e.src; end
    chk("busy", int'(bus.busy), int'(e.busy));
    chk("reg_write", int'(bus.reg_write), int'(e.we));
    chk("reg_dst_sel", int'(bus.reg_dst_sel), int'(hd));
    chk("wb_src_sel", int'(bus.wb_src_sel), int'(hs));
    chk("done", int'(bus.done), int'(e.done));
    chk("err", int'(bus.err), int'(e.err));
    if (bus.reg_write) begin
      wr_n++;
      wlog.push_back({bus.reg_dst_sel, bus.wb_src_sel});
    end
    if (bus.done) done_n++;
    if (bus.err) err_n++;
    if (bus.busy) busy_n++;
  end

  task automatic run_cmd(input logic [2:0] o, input logic nm, input int wait_lo, input bit spur);
    int len;
    @(posedge clk); #1;
    wr_n = 0; done_n = 0; err_n = 0; busy_n = 0;
    bus.start = 1'b1; bus.op = o; bus.needs_mem = nm; bus.mem_ready = 1'b0;
    plan(o, nm, wait_lo, len);
    for (int k = 1; k <= len; k++) begin
      @(posedge clk); #1;
      bus.start = spur && k == 1 && len > 1;
      if (bus.start) bus.op = 3'd0;
      bus.mem_ready = (k > wait_lo);
    end
  endtask

  task automatic expect_counts(input string name, input int w, input int d, input int e,
                               input int b);
    @(negedge clk); #1;
    chk({name, " writes"}, wr_n, w);
    chk({name, " dones"}, done_n, d);
    chk({name, " errs"}, err_n, e);
    chk({name, " busy cycles"}, busy_n, b);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int len;
    bus.start = 1'b0; bus.op = '0; bus.needs_mem = 1'b0; bus.mem_ready = 1'b0;
    #3;
    chk("reset outputs", int'({bus.reg_dst_sel, bus.wb_src_sel, bus.reg_write, bus.busy,
                               bus.done, bus.err}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Asynchronous reset in the middle of a JAL write.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd2;
    plan(3'd2, 1'b0, 0, len);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("jal wr1 reg_write", int'(bus.reg_write), 1);
    chk("jal wr1 dst/src", int'({bus.reg_dst_sel, bus.wb_src_sel}), 5'b011_10);
    #2 reset = 1'b1;
    q.delete(); hd = '0; hs = '0;
    #1;
    chk("async reset reg_write", int'(bus.reg_write), 0);
    chk("async reset busy/dst", int'({bus.busy, bus.reg_dst_sel}), 0);
    done_n = 0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("no done after reset", done_n, 0);

    run_cmd(3'd0, 1'b0, 0, 1'b0);
    expect_counts("rtype", 1, 1, 0, 2);
    run_cmd(3'd4, 1'b0, 3, 1'b1);
    expect_counts("pop", 2, 1, 0, 7);
    run_cmd(3'd1, 1'b1, 255, 1'b0);
    expect_counts("load timeout", 0, 1, 1, 16);
    run_cmd(3'd1, 1'b1, 14, 1'b1);
    expect_counts("load ready at limit", 1, 1, 0, 17);
    run_cmd(3'd1, 1'b1, 15, 1'b0);
    expect_counts("load late", 0, 1, 1, 16);
    run_cmd(3'd7, 1'b0, 0, 1'b0);
    expect_counts("illegal 111", 0, 1, 1, 1);
    run_cmd(3'd6, 1'b0, 0, 1'b0);
    expect_counts("illegal 110", 0, 1, 1, 1);
    run_cmd(3'd1, 1'b0, 0, 1'b1);
    expect_counts("itype alu", 1, 1, 0, 2);
    run_cmd(3'd5, 1'b0, 0, 1'b0);
    expect_counts("rs write", 1, 1, 0, 2);

    // Back-to-back JAL then PUSH (needs_mem must not matter for PUSH).
    wlog.delete();
    run_cmd(3'd2, 1'b0, 0, 1'b0);
    run_cmd(3'd3, 1'b1, 0, 1'b0);
    @(negedge clk); #1;
    chk("b2b write count", wlog.size(), 2);
    if (wlog.size() == 2) begin
      chk("b2b first write", int'(wlog[0]), 5'b011_10);
      chk("b2b second write", int'(wlog[1]), 5'b010_11);
    end
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
